// File: rtl/split_4_pkg.sv
// Shared types, widths and the split_4 constraint predicate for the candidate generator.
package split_4_pkg;

    localparam int W12    = 10;
    localparam int W14    = 13;
    localparam int W23    = 14;
    localparam int CAND_W = W12 + W14 + W23;

    localparam logic [15:0] EXCL14 = 16'h160;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        CHECK,
        HOLD
    } state_t;

    function automatic logic split_4_sat(
        input logic [W12-1:0] v12,
        input logic [W14-1:0] v14,
        input logic [W23-1:0] v23
    );
        logic [15:0] v14_ext;
        v14_ext = {3'b000, v14};
        return ((v12 != '0) || (v14 != '0))
            && (v14_ext != EXCL14)
            && ((v14 == '0) || (v23 != '0));
    endfunction

endpackage

// File: rtl/split_4_lfsr64.sv
// 64-bit Fibonacci LFSR (taps 64,63,61,60) with seed load and zero-seed substitution.
module split_4_lfsr64 #(
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
    parameter int          OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [63:0]      load_val,
    input  logic             step,
    output logic [OUT_W-1:0] state
);

    logic [63:0] lfsr;
    logic        fb;

    assign fb = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (load) begin
            // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
            lfsr <= (load_val == 64'd0) ? SEED : load_val;
        end else if (step) begin
            lfsr <= {lfsr[62:0], fb};
        end
    end

    assign state = lfsr[OUT_W-1:0];

endmodule

// File: rtl/split_4_gen.sv
// Sequential split_4 candidate generator: draws LFSR slices, retries until the
// predicate holds or the try budget is spent, and presents the result valid/ready.
module split_4_gen
    import split_4_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 1024,
    parameter logic [63:0] SEED      = 64'h0000_0000_0000_0001
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           seed_load,
    input  logic [63:0]    seed_val,
    input  logic           req_valid,
    output logic           req_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sat,
    output logic [W12-1:0] out_var_12,
    output logic [W14-1:0] out_var_14,
    output logic [W23-1:0] out_var_23,
    output logic [15:0]    out_tries
);

    localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

    state_t            state;
    logic [15:0]       tries;
    logic [CAND_W-1:0] cand;
    logic              lfsr_load;
    logic              lfsr_step;

    assign lfsr_load = (state == IDLE) && seed_load;
    assign lfsr_step = (state == DRAW);

    split_4_lfsr64 #(
        .SEED  (SEED),
        .OUT_W (CAND_W)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (seed_val),
        .step     (lfsr_step),
        .state    (cand)
    );

    assign out_tries = tries;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tries      <= '0;
            req_ready  <= 1'b1;
            out_valid  <= 1'b0;
            out_sat    <= 1'b0;
            out_var_12 <= '0;
            out_var_14 <= '0;
            out_var_23 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A seed load in the same cycle wins; the request waits.
                    if (!seed_load && req_valid) begin
                        state     <= DRAW;
                        tries     <= '0;
                        req_ready <= 1'b0;
                        out_sat   <= 1'b0;
                    end
                end
                DRAW: begin
                    out_var_12 <= cand[W12-1:0];
                    out_var_14 <= cand[W12 +: W14];
                    out_var_23 <= cand[W12+W14 +: W23];
                    tries      <= tries + 16'd1;
                    state      <= CHECK;
                end
                CHECK: begin
                    if (split_4_sat(out_var_12, out_var_14, out_var_23)) begin
                        out_sat   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tries == MAX_T) begin
                        out_sat   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        state <= DRAW;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_4_gen.sv
// Directed bench for split_4_gen: latency, retry, budget, stall, reset and seed-load behaviour.
module tb_split_4_gen;
    import split_4_pkg::*;

    localparam logic [63:0] SEED_D = 64'h0000_0000_0000_0001;
    localparam int          MAX_A  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           seed_load = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
    logic [63:0]    seed_val = '0;
    logic           req_ready, out_valid, out_sat;
    logic [W12-1:0] out_var_12;
    logic [W14-1:0] out_var_14;
    logic [W23-1:0] out_var_23;
    logic [15:0]    out_tries;

    logic           seed_load_b = 1'b0, req_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [63:0]    seed_val_b = '0;
    logic           req_ready_b, out_valid_b, out_sat_b;
    logic [W12-1:0] out_var_12_b;
    logic [W14-1:0] out_var_14_b;
    logic [W23-1:0] out_var_23_b;
    logic [15:0]    out_tries_b;

    split_4_gen #(.MAX_TRIES(MAX_A), .SEED(SEED_D)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_val(seed_val),
        .req_valid(req_valid), .req_ready(req_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_sat(out_sat), .out_var_12(out_var_12),
        .out_var_14(out_var_14), .out_var_23(out_var_23), .out_tries(out_tries)
    );

    split_4_gen #(.MAX_TRIES(1), .SEED(SEED_D)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load_b), .seed_val(seed_val_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_sat(out_sat_b), .out_var_12(out_var_12_b),
        .out_var_14(out_var_14_b), .out_var_23(out_var_23_b), .out_tries(out_tries_b)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_lfsr;

    function automatic logic [63:0] m_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [53:0] pack(input logic s, input logic [9:0] a,
                                         input logic [12:0] b, input logic [13:0] c,
                                         input logic [15:0] t);
        return {s, a, b, c, t};
    endfunction

    // Reference search over the bench's own LFSR copy; returns packed expectation.
    task automatic model_run(input int max_t, output logic [53:0] exp_v, output int etries);
        logic [9:0]  e12;
        logic [12:0] e14;
        logic [13:0] e23;
        logic        esat;
        etries = 0;
        esat   = 1'b0;
        e12 = '0; e14 = '0; e23 = '0;
        while (1) begin
            e12 = m_lfsr[9:0];
            e14 = m_lfsr[22:10];
            e23 = m_lfsr[36:23];
            m_lfsr = m_step(m_lfsr);
            etries++;
            esat = split_4_sat(e12, e14, e23);
            if (esat || etries == max_t) break;
        end
        exp_v = pack(esat, e12, e14, e23, 16'(etries));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request on the main DUT; lat = cycles from request edge to out_valid, -1 on timeout.
    task automatic req_a(output int lat);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 3000) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_a(input int delay);
        repeat (delay) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic load_a(input logic [63:0] s);
        seed_load = 1'b1;
        seed_val  = s;
        tick();
        seed_load = 1'b0;
    endtask

    function automatic logic [53:0] act_a();
        return pack(out_sat, out_var_12, out_var_14, out_var_23, out_tries);
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || act_a() !== 54'd0) begin
            n_bad++;
            $display("FAIL reset_hold: valid=%b outs=%h, want 0/0", out_valid, act_a());
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || act_a() !== 54'd0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b valid=%b outs=%h, want 1/0/0", req_ready, out_valid, act_a());
        end
        n_cmp++;
        if (req_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_tries_b !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state_b: rdy=%b valid=%b tries=%0d", req_ready_b, out_valid_b, out_tries_b);
        end
        m_lfsr = SEED_D;
    endtask

    task automatic test_first_try();
        int lat;
        load_a(64'h1);
        req_a(lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL first_try_latency: got %0d, want 2", lat);
        end
        n_cmp++;
        if (act_a() !== pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1)) begin
            n_bad++;
            $display("FAIL first_try_result: got %h, want %h", act_a(), pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1));
        end
        release_a(0);
        m_lfsr = m_step(64'h1);
    endtask

    // Seed 0x401 gives v12=1, v14=1, v23=0: rejected by the v14/v23 clause.
    task automatic test_seed_401();
        int lat, et;
        logic [53:0] ev;
        load_a(64'h401);
        m_lfsr = 64'h401;
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (lat !== 2 * et || act_a() !== ev || out_tries < 16'd2) begin
            n_bad++;
            $display("FAIL seed_401: lat=%0d got %h, want lat=%0d %h", lat, act_a(), 2 * et, ev);
        end
        release_a(1);
    endtask

    task automatic test_reject_first();
        int lat, et;
        logic [53:0] ev;
        load_a(64'h0000_0000_0285_8000);
        m_lfsr = 64'h0000_0000_0285_8000;
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (out_tries < 16'd2 || !split_4_sat(out_var_12, out_var_14, out_var_23)
            || out_var_14 === 13'h160 || out_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL reject_first_props: tries=%0d v14=%h sat=%b", out_tries, out_var_14, out_sat);
        end
        n_cmp++;
        if (lat !== 4 || act_a() !== pack(1'b1, 10'd0, 13'h2c0, 14'd10, 16'd2)) begin
            n_bad++;
            $display("FAIL reject_first_value: lat=%0d got %h, want lat=4 %h", lat, act_a(),
                     pack(1'b1, 10'd0, 13'h2c0, 14'd10, 16'd2));
        end
        n_cmp++;
        if (act_a() !== ev) begin
            n_bad++;
            $display("FAIL reject_first_model: got %h, want %h", act_a(), ev);
        end
        release_a(0);
    endtask

    task automatic test_budget();
        int lat;
        seed_load_b = 1'b1;
        seed_val_b  = 64'h0000_0000_0005_8000;
        tick();
        seed_load_b = 1'b0;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 100) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL budget_latency: got %0d, want 2", lat);
        end
        n_cmp++;
        if (pack(out_sat_b, out_var_12_b, out_var_14_b, out_var_23_b, out_tries_b)
            !== pack(1'b0, 10'd0, 13'h160, 14'd0, 16'd1)) begin
            n_bad++;
            $display("FAIL budget_result: sat=%b v14=%h tries=%0d, want 0/160/1",
                     out_sat_b, out_var_14_b, out_tries_b);
        end
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
    endtask

    task automatic test_hold_stall();
        int lat, et;
        logic [53:0] ev;
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (lat !== 2 * et || act_a() !== ev) begin
            n_bad++;
            $display("FAIL stall_result: lat=%0d got %h, want lat=%0d %h", lat, act_a(), 2 * et, ev);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || req_ready !== 1'b0 || act_a() !== ev) begin
                n_bad++;
                $display("FAIL stall_stable[%0d]: valid=%b rdy=%b got %h, want 1/0 %h",
                         i, out_valid, req_ready, act_a(), ev);
            end
        end
        release_a(0);
        n_cmp++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: valid=%b rdy=%b, want 0/1", out_valid, req_ready);
        end
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (lat !== 2 * et || act_a() !== ev) begin
            n_bad++;
            $display("FAIL back_to_back: lat=%0d got %h, want lat=%0d %h", lat, act_a(), 2 * et, ev);
        end
        release_a(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        load_a(64'h0000_0000_0285_8000);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || act_a() !== 54'd0) begin
            n_bad++;
            $display("FAIL reset_mid: valid=%b rdy=%b outs=%h, want 0/1/0", out_valid, req_ready, act_a());
        end
        #4;
        rst_n = 1'b1;
        tick();
        m_lfsr = SEED_D;
        req_a(lat);
        n_cmp++;
        if (lat !== 2 || act_a() !== pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1)) begin
            n_bad++;
            $display("FAIL reset_mid_seed: lat=%0d got %h, want lat=2 %h", lat, act_a(),
                     pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1));
        end
        release_a(0);
        m_lfsr = m_step(SEED_D);
    endtask

    task automatic test_seed_priority();
        int lat, et;
        logic [53:0] ev;
        seed_load = 1'b1;
        seed_val  = 64'h0000_0000_0285_8000;
        req_valid = 1'b1;
        tick();
        seed_load = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL seed_priority: rdy=%b valid=%b, want 1/0", req_ready, out_valid);
        end
        m_lfsr = 64'h0000_0000_0285_8000;
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (lat !== 2 * et || act_a() !== ev) begin
            n_bad++;
            $display("FAIL seed_priority_taken: lat=%0d got %h, want lat=%0d %h", lat, act_a(), 2 * et, ev);
        end
        release_a(0);
        load_a(64'd0);
        m_lfsr = SEED_D;
        model_run(MAX_A, ev, et);
        req_a(lat);
        n_cmp++;
        if (lat !== 2 || act_a() !== pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1)) begin
            n_bad++;
            $display("FAIL zero_seed: lat=%0d got %h, want lat=2 %h", lat, act_a(),
                     pack(1'b1, 10'd1, 13'd0, 14'd0, 16'd1));
        end
        release_a(0);
    endtask

    task automatic test_random();
        int lat, et;
        logic [53:0] ev;
        for (int i = 0; i < 1000; i++) begin
            model_run(MAX_A, ev, et);
            req_a(lat);
            n_cmp++;
            if (lat < 0) begin
                n_bad++;
                $display("FAIL random_timeout[%0d]: out_valid never rose", i);
                break;
            end
            if (lat !== 2 * et || act_a() !== ev) begin
                n_bad++;
                $display("FAIL random_result[%0d]: lat=%0d got %h, want lat=%0d %h", i, lat, act_a(), 2 * et, ev);
            end
            if (out_sat === 1'b1) begin
                n_cmp++;
                if (!split_4_sat(out_var_12, out_var_14, out_var_23)) begin
                    n_bad++;
                    $display("FAIL random_sat[%0d]: %h %h %h fails predicate", i, out_var_12, out_var_14, out_var_23);
                end
            end
            release_a(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_first_try();
        test_seed_401();
        test_reject_first();
        test_budget();
        test_hold_stall();
        test_reset_mid();
        test_seed_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
